// File: rtl/rf_wb_arbiter_if.sv
// Bundle of pipeline WB, MDU result/issue and register-file write-port signals.
// master = pipeline/MDU side, slave = arbiter side.
interface rf_wb_arbiter_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  logic [4:0]    pipe_wn;
  logic [31:0]   pipe_d;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [4:0]    mdu_wn;
  logic [31:0]   mdu_d;
  logic          mdu_issue;
  logic [4:0]    mdu_issue_rd;
  logic          rf_we;
  logic [4:0]    rf_wn;
  logic [31:0]   rf_d;
  logic [31:0]   busy;
  logic [CW-1:0] fifo_count;
  logic          wb_stall;

  modport master (
    output pipe_we, pipe_wn, pipe_d,
    output mdu_valid, mdu_wn, mdu_d, mdu_issue, mdu_issue_rd,
    input  mdu_ready, rf_we, rf_wn, rf_d, busy, fifo_count, wb_stall
  );

  modport slave (
    input  pipe_we, pipe_wn, pipe_d,
    input  mdu_valid, mdu_wn, mdu_d, mdu_issue, mdu_issue_rd,
    output mdu_ready, rf_we, rf_wn, rf_d, busy, fifo_count, wb_stall
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB wins, MDU results queue and drain into idle slots.
// Optional STARVE_GUARD_EN: a waiting FIFO head eventually forces wb_stall and takes the port.
module rf_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic            clk,
  input logic            clrn,
  rf_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  wn;
    logic [31:0] d;
  } mdu_ent_t;

  mdu_ent_t      r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_busy;

  mdu_ent_t      w_head;
  logic          w_empty;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_stall;
  logic          w_sel_we;
  logic [4:0]    w_sel_wn;
  logic [31:0]   w_sel_d;
  logic [31:0]   w_busy_nxt;

  assign w_head  = r_mem[r_rptr];
  assign w_empty = (r_count == '0);
  // Ready looks only at occupancy so the MDU never sees a combinational loop through valid.
  assign w_ready = clrn && (r_count < CW'(DEPTH));
  assign w_push  = bus.mdu_valid && w_ready;

  always_comb begin
    w_sel_we = 1'b0;
    w_sel_wn = '0;
    w_sel_d  = '0;
    w_pop    = 1'b0;
    if (bus.pipe_we && !w_stall) begin
      w_sel_we = 1'b1;
      w_sel_wn = bus.pipe_wn;
      w_sel_d  = bus.pipe_d;
    end else if (!w_empty) begin
      w_sel_we = 1'b1;
      w_sel_wn = w_head.wn;
      w_sel_d  = w_head.d;
      w_pop    = clrn;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers/count decide what is live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {bus.mdu_wn, bus.mdu_d};
  end

  // Clear first, then set, so a new issue to the register just retired stays outstanding.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop && (w_head.wn != 5'd0)) w_busy_nxt[w_head.wn] = 1'b0;
    if (bus.mdu_issue && (bus.mdu_issue_rd != 5'd0)) w_busy_nxt[bus.mdu_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                        r_starve <= '0;
    else if (w_empty || w_pop)        r_starve <= '0;
    else if (r_starve < SW'(STARVE_LIMIT)) r_starve <= r_starve + 1'b1;
  end

  assign w_stall = clrn && (r_starve >= SW'(STARVE_LIMIT));
`else
  // Pipeline priority is absolute; the limit only matters with the guard built in.
  assign w_stall = 1'b0 && (STARVE_LIMIT > 0);
`endif

  assign bus.mdu_ready  = w_ready;
  assign bus.rf_we      = clrn && w_sel_we && (w_sel_wn != 5'd0);
  assign bus.rf_wn      = w_sel_wn;
  assign bus.rf_d       = w_sel_d;
  assign bus.busy       = r_busy;
  assign bus.fifo_count = r_count;
  assign bus.wb_stall   = w_stall;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter (default build): directed scenarios plus random traffic
// against a queue-based reference model; a monitor pops expectations and compares.
module tb_rf_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();
  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  typedef struct {
    bit          rst;
    bit          we;
    logic [4:0]  wn;
    logic [31:0] d;
    bit          ready;
    logic [31:0] busy;
    int          count;
  } exp_t;

  typedef struct {
    logic [4:0]  wn;
    logic [31:0] d;
  } ent_t;

  exp_t        expq[$];
  ent_t        mq[$];
  logic [31:0] m_busy = '0;
  int          tests = 0;
  int          fails = 0;

  // MDU result source: holds its result until accepted.
  bit          src_v = 1'b0;
  logic [4:0]  src_wn = '0;
  logic [31:0] src_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; pushes the expected outputs and advances the model past the edge.
  task automatic cycle(input logic rn, input logic pe, input logic [4:0] pwn,
                       input logic [31:0] pd, input logic iss, input logic [4:0] ird);
    exp_t e;
    ent_t h;
    bit   pop;
    @(negedge clk);
    #1;
    clrn             = rn;
    bus.pipe_we      = pe;
    bus.pipe_wn      = pwn;
    bus.pipe_d       = pd;
    bus.mdu_valid    = src_v;
    bus.mdu_wn       = src_wn;
    bus.mdu_d        = src_d;
    bus.mdu_issue    = iss;
    bus.mdu_issue_rd = ird;
    e.rst = !rn; e.we = 1'b0; e.wn = '0; e.d = '0;
    e.ready = 1'b0; e.busy = '0; e.count = 0;
    pop = 1'b0;
    if (!rn) begin
      expq.push_back(e);
      mq.delete();
      m_busy = '0;
      src_v  = 1'b0;
    end else begin
      e.ready = (mq.size() < DEPTH);
      e.count = mq.size();
      e.busy  = m_busy;
      if (pe) begin
        e.we = (pwn != 0); e.wn = pwn; e.d = pd;
      end else if (mq.size() > 0) begin
        e.we = (mq[0].wn != 0); e.wn = mq[0].wn; e.d = mq[0].d; pop = 1'b1;
      end
      expq.push_back(e);
      if (pop) begin
        h = mq.pop_front();
        if (h.wn != 0) m_busy[h.wn] = 1'b0;
      end
      if (src_v && e.ready) begin
        h.wn = src_wn; h.d = src_d;
        mq.push_back(h);
        src_v = 1'b0;
      end
      if (iss && ird != 0) m_busy[ird] = 1'b1;
    end
  endtask

  task automatic offer(input logic [4:0] wn, input logic [31:0] d);
    src_v = 1'b1; src_wn = wn; src_d = d;
  endtask

  // Monitor: samples mid-cycle, after the driver has settled inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rf_we", 32'(bus.rf_we), 32'(e.we));
        chk("mdu_ready", 32'(bus.mdu_ready), 32'(e.ready));
        chk("busy", bus.busy, e.busy);
        chk("fifo_count", 32'(bus.fifo_count), 32'(e.count));
        chk("wb_stall", 32'(bus.wb_stall), 32'd0);
        if (e.we) begin
          chk("rf_wn", 32'(bus.rf_wn), 32'(e.wn));
          chk("rf_d", bus.rf_d, e.d);
        end
      end
    end
  end

  initial begin
    int t;
    logic [4:0] lst [3];
    int idx;
    bus.pipe_we = 1'b0; bus.pipe_wn = '0; bus.pipe_d = '0;
    bus.mdu_valid = 1'b0; bus.mdu_wn = '0; bus.mdu_d = '0;
    bus.mdu_issue = 1'b0; bus.mdu_issue_rd = '0;

    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // pass-through pipeline write
    cycle(1, 1, 5'd5, 32'h1234, 0, 0);
    // collision: r9 queued behind three pipeline writes
    cycle(1, 0, 0, 0, 1, 5'd9);
    offer(5'd9, 32'hAA);
    repeat (3) cycle(1, 1, 5'd3, 32'h3333, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0, 0);
    // full FIFO with pipeline holding the port; order r10,r11,r12
    lst[0] = 5'd10; lst[1] = 5'd11; lst[2] = 5'd12;
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      if (!src_v && idx < 3) begin offer(lst[idx], 32'hC0 + 32'(idx)); idx++; end
      cycle(1, (i < 6), 5'd4, 32'h4444, 0, 0);
    end
    // scoreboard race: reissue rd=7 on the edge the old r7 result pops
    cycle(1, 0, 0, 0, 1, 5'd7);
    offer(5'd7, 32'h77);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 5'd7);
    offer(5'd0, 32'hDEAD);
    cycle(1, 0, 0, 0, 1, 5'd0);
    repeat (3) cycle(1, 0, 0, 0, 0, 0);
    // no guard: a queued entry never gets the port under continuous pipeline writes
    offer(5'd20, 32'h2020);
    repeat (12) cycle(1, 1, 5'd1, 32'h1, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0, 0);
    // mid-run reset with two entries queued
    cycle(1, 0, 0, 0, 1, 5'd13);
    offer(5'd13, 32'h13);
    cycle(1, 1, 5'd2, 32'h2, 0, 0);
    offer(5'd14, 32'h14);
    cycle(1, 1, 5'd2, 32'h2, 0, 0);
    cycle(1, 1, 5'd2, 32'h2, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if (!src_v && $urandom_range(0, 2) == 0) offer(5'($urandom), $urandom);
      cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) != 0), 5'($urandom), $urandom,
            ($urandom_range(0, 3) == 0), 5'($urandom));
    end

    t = 0;
    while (expq.size() > 0 && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    #4;
    if (expq.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
